// File: rtl/seg7_scan4.sv
// Four-digit common-anode seven-segment scanner.
// Inputs are snapshotted once per frame, and each digit slot starts with a ghost-blanking window.
module seg7_scan4 #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_CYC   = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] digits,
    input  logic [3:0]  dp_in,
    input  logic        lz_en,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic        frame_tick
);

    localparam int              CNT_W   = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    typedef struct packed {
        logic [15:0] digits;
        logic [3:0]  dp;
        logic        lz;
    } snap_t;

    logic [CNT_W-1:0] r_cnt, w_cnt_nx;
    logic [1:0]       r_idx, w_idx_nx;
    snap_t            r_snap, w_snap_nx;
    logic             r_load, w_load, w_wrap, w_blank, w_sup;
    logic [3:0]       w_hi_zero, w_nib, w_an_nx;
    logic [6:0]       w_seg_nx;
    logic             w_dp_nx;

    function automatic logic [6:0] seg_dec(input logic [3:0] n);
        case (n)
            4'd0:    seg_dec = 7'h40;
            4'd1:    seg_dec = 7'h79;
            4'd2:    seg_dec = 7'h24;
            4'd3:    seg_dec = 7'h30;
            4'd4:    seg_dec = 7'h19;
            4'd5:    seg_dec = 7'h12;
            4'd6:    seg_dec = 7'h02;
            4'd7:    seg_dec = 7'h78;
            4'd8:    seg_dec = 7'h00;
            4'd9:    seg_dec = 7'h10;
            default: seg_dec = 7'h3F;
        endcase
    endfunction

    // Outputs are flopped, so they are decoded from the next-state values.
    always_comb begin
        w_wrap    = (r_cnt == CNT_MAX);
        w_cnt_nx  = w_wrap ? '0 : r_cnt + 1'b1;
        w_idx_nx  = w_wrap ? r_idx + 2'd1 : r_idx;
        w_load    = r_load | (w_wrap & (r_idx == 2'd3));
        w_snap_nx = r_snap;
        if (w_load)
            w_snap_nx = '{digits: digits, dp: dp_in, lz: lz_en};
    end

    generate
        if (BLANK_CYC == 0) begin : g_noblank
            assign w_blank = 1'b0;
        end else begin : g_blank
            assign w_blank = (w_cnt_nx < CNT_W'(BLANK_CYC));
        end
        for (genvar k = 0; k < 4; k++) begin : g_hz
            assign w_hi_zero[k] = (w_snap_nx.digits[15:4*k] == '0);
        end
    endgenerate

    always_comb begin
        w_nib    = w_snap_nx.digits[{w_idx_nx, 2'b00} +: 4];
        w_sup    = w_snap_nx.lz && (w_idx_nx != 2'd0) && w_hi_zero[w_idx_nx];
        w_seg_nx = 7'h7F;
        w_dp_nx  = 1'b1;
        w_an_nx  = 4'hF;
        if (!w_blank) begin
            w_an_nx  = ~(4'b0001 << w_idx_nx);
            w_seg_nx = w_sup ? 7'h7F : seg_dec(w_nib);
            w_dp_nx  = ~w_snap_nx.dp[w_idx_nx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_idx      <= '0;
            r_snap     <= '0;
            r_load     <= 1'b1;
            seg        <= 7'h7F;
            dp         <= 1'b1;
            an         <= 4'hF;
            frame_tick <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_nx;
            r_idx      <= w_idx_nx;
            r_snap     <= w_snap_nx;
            r_load     <= 1'b0;
            seg        <= w_seg_nx;
            dp         <= w_dp_nx;
            an         <= w_an_nx;
            frame_tick <= w_load;
        end
    end

endmodule

// File: tb/tb_seg7_scan4.sv
// Randomized self-checking bench for seg7_scan4, with BLANK_CYC=2 and BLANK_CYC=0 instances.
// Expected outputs come from a time-since-reset model of the scan pattern.
module tb_seg7_scan4;

    localparam int R = 8;
    localparam int B = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] digits = '0;
    logic [3:0]  dp_in = '0;
    logic        lz_en = 1'b0;
    logic [6:0]  seg, seg0;
    logic        dp, dp0, ft, ft0;
    logic [3:0]  an, an0;

    seg7_scan4 #(.REFRESH_DIV(R), .BLANK_CYC(B)) dut (
        .clk(clk), .rst_n(rst_n), .digits(digits), .dp_in(dp_in), .lz_en(lz_en),
        .seg(seg), .dp(dp), .an(an), .frame_tick(ft));

    seg7_scan4 #(.REFRESH_DIV(R), .BLANK_CYC(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .digits(digits), .dp_in(dp_in), .lz_en(lz_en),
        .seg(seg0), .dp(dp0), .an(an0), .frame_tick(ft0));

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          t = 0;
    logic [15:0] m_dig = '0;
    logic [3:0]  m_dp = '0;
    logic        m_lz = 1'b0;
    logic [12:0] exp_a, exp_b;
    logic [6:0]  seg_tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                  7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    // Output bundle {seg, dp, an, frame_tick} expected t edges after reset release.
    function automatic logic [12:0] model(input int tt, input int blank);
        int         cnt, idx;
        logic       tick, sup;
        logic [3:0] nib;
        logic [6:0] s;
        if (tt <= 0) return {7'h7F, 1'b1, 4'hF, 1'b0};
        cnt  = tt % R;
        idx  = (tt / R) % 4;
        tick = (tt == 1) || (tt % (4 * R) == 0);
        if (cnt < blank) return {7'h7F, 1'b1, 4'hF, tick};
        nib = m_dig[idx*4 +: 4];
        sup = m_lz && (idx > 0) && ((m_dig >> (idx * 4)) == 16'h0);
        s   = sup ? 7'h7F : (nib > 4'd9 ? 7'h3F : seg_tbl[nib]);
        return {s, ~m_dp[idx], ~(4'b0001 << idx), tick};
    endfunction

    task automatic adv();
        if (t + 1 == 1 || (t + 1) % (4 * R) == 0) begin
            m_dig = digits;
            m_dp  = dp_in;
            m_lz  = lz_en;
        end
        @(posedge clk);
        #1;
        t++;
        exp_a = model(t, B);
        exp_b = model(t, 0);
    endtask

    task automatic reset_release();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        t = 0;
    endtask

    task automatic test_reset();
        reset_release();
        exp_a = model(0, B);
        n_cmp += 2;
        if ({seg, dp, an, ft} !== exp_a) begin
            n_bad++; $display("FAIL reset_a got=%h exp=%h", {seg, dp, an, ft}, exp_a);
        end
        if ({seg0, dp0, an0, ft0} !== exp_a) begin
            n_bad++; $display("FAIL reset_b got=%h exp=%h", {seg0, dp0, an0, ft0}, exp_a);
        end
    endtask

    task automatic test_scan(input string name, input logic [15:0] d, input logic [3:0] p,
                             input logic lz, input int ncyc);
        int nblank = 0;
        digits = d; dp_in = p; lz_en = lz;
        for (int i = 0; i < ncyc; i++) begin
            adv();
            if (an == 4'hF) nblank++;
            n_cmp += 2;
            if ({seg, dp, an, ft} !== exp_a) begin
                n_bad++;
                $display("FAIL %s_a t=%0d got=%h exp=%h", name, t, {seg, dp, an, ft}, exp_a);
            end
            if ({seg0, dp0, an0, ft0} !== exp_b) begin
                n_bad++;
                $display("FAIL %s_b t=%0d got=%h exp=%h", name, t, {seg0, dp0, an0, ft0}, exp_b);
            end
        end
        // Whole frames must contain exactly BLANK_CYC blank cycles per slot.
        if (ncyc % (4 * R) == 0) begin
            n_cmp++;
            if (nblank !== B * 4 * (ncyc / (4 * R))) begin
                n_bad++; $display("FAIL %s_blankcnt got=%0d exp=%0d", name, nblank, B * 4 * (ncyc / (4 * R)));
            end
        end
    endtask

    task automatic test_tearing();
        digits = 16'h1234; lz_en = 1'b0; dp_in = 4'h0;
        while (!((t % (4 * R)) == R + 3)) adv();
        digits = 16'h5678;
        for (int i = 0; i < 3 * 4 * R; i++) begin
            adv();
            n_cmp += 2;
            if ({seg, dp, an, ft} !== exp_a) begin
                n_bad++; $display("FAIL tear_a t=%0d got=%h exp=%h", t, {seg, dp, an, ft}, exp_a);
            end
            if ({seg0, dp0, an0, ft0} !== exp_b) begin
                n_bad++; $display("FAIL tear_b t=%0d got=%h exp=%h", t, {seg0, dp0, an0, ft0}, exp_b);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 9) == 0) digits = 16'($urandom);
            if ($urandom_range(0, 9) == 0) dp_in = 4'($urandom);
            if ($urandom_range(0, 19) == 0) lz_en = 1'($urandom);
            if ($urandom_range(0, 3) == 0) digits = digits & 16'h00FF;
            adv();
            n_cmp += 2;
            if ({seg, dp, an, ft} !== exp_a) begin
                n_bad++; $display("FAIL rand_a t=%0d got=%h exp=%h", t, {seg, dp, an, ft}, exp_a);
            end
            if ({seg0, dp0, an0, ft0} !== exp_b) begin
                n_bad++; $display("FAIL rand_b t=%0d got=%h exp=%h", t, {seg0, dp0, an0, ft0}, exp_b);
            end
        end
    endtask

    task automatic test_reset_mid();
        int nf0 = 0;
        digits = 16'h9876; lz_en = 1'b0; dp_in = 4'hA;
        while ((t % (4 * R)) != 2 * R + 5) adv();
        rst_n = 1'b0;
        #1;
        exp_a = model(0, B);
        n_cmp += 2;
        if ({seg, dp, an, ft} !== exp_a) begin
            n_bad++; $display("FAIL rstmid_a got=%h exp=%h", {seg, dp, an, ft}, exp_a);
        end
        if ({seg0, dp0, an0, ft0} !== exp_a) begin
            n_bad++; $display("FAIL rstmid_b got=%h exp=%h", {seg0, dp0, an0, ft0}, exp_a);
        end
        reset_release();
        for (int i = 0; i < 3 * 4 * R; i++) begin
            adv();
            if (an0 == 4'hF) nf0++;
            n_cmp += 2;
            if ({seg, dp, an, ft} !== exp_a) begin
                n_bad++; $display("FAIL rstrun_a t=%0d got=%h exp=%h", t, {seg, dp, an, ft}, exp_a);
            end
            if ({seg0, dp0, an0, ft0} !== exp_b) begin
                n_bad++; $display("FAIL rstrun_b t=%0d got=%h exp=%h", t, {seg0, dp0, an0, ft0}, exp_b);
            end
        end
        n_cmp++;
        if (nf0 !== 0) begin
            n_bad++; $display("FAIL noblank_anF got=%0d exp=0", nf0);
        end
    endtask

    initial begin
        test_reset();
        test_scan("scan1234", 16'h1234, 4'h0, 1'b0, 3 * 4 * R);
        test_scan("lz0050",   16'h0050, 4'h0, 1'b1, 2 * 4 * R);
        test_scan("nolz0050", 16'h0050, 4'h0, 1'b0, 2 * 4 * R);
        test_scan("inv00A0",  16'h00A0, 4'h0, 1'b0, 2 * 4 * R);
        test_scan("lz00A0",   16'h00A0, 4'h0, 1'b1, 2 * 4 * R);
        test_scan("dp0100",   16'h0000, 4'b0100, 1'b1, 2 * 4 * R);
        test_tearing();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
